// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decodes CPU memory commands onto a synchronous-read
// RAM plus a write-only LED register and a read-only switch register, with a
// one-cycle ready pulse, programmable wait states and a sticky bus-error flag.
module mem_bus_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned RAM_WORDS   = 256,
    parameter int unsigned LED_ADDR    = 'h100,
    parameter int unsigned SW_ADDR     = 'h140,
    parameter int unsigned IO_W        = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [IO_W-1:0]   sw_in,
    output logic [IO_W-1:0]   led_out,
    output logic              bus_err
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    localparam logic [1:0] CmdRead    = 2'b01;
    localparam logic [1:0] CmdWrite   = 2'b10;
    localparam logic [1:0] CmdIllegal = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              is_write_q;
    logic [3:0]        wait_q;
    logic [IO_W-1:0]   sw_meta_q, sw_sync_q;
    logic [IO_W-1:0]   led_q;
    logic              bus_err_q;

    logic cmd_valid;
    logic hit_ram, hit_led, hit_sw;
    logic last_access;
    logic access_err;

    // Command qualification and address decode of the latched address
    always_comb begin
        cmd_valid   = (mem_cmd == CmdRead) || (mem_cmd == CmdWrite);
        hit_ram     = 32'(addr_q) < RAM_WORDS;
        hit_led     = 32'(addr_q) == LED_ADDR;
        hit_sw      = 32'(addr_q) == SW_ADDR;
        last_access = (state_q == StAccess) && (wait_q == 4'd0);
        // RAM takes priority; LED is write-only, SW is read-only
        if (is_write_q) begin
            access_err = !(hit_ram || hit_led);
        end else begin
            access_err = !(hit_ram || hit_sw);
        end
    end

    // Next-state logic for the IDLE -> ACCESS -> RESP handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = StAccess;
            StAccess: if (wait_q == 4'd0) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the transaction in IDLE and count down wait states in ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            data_q     <= '0;
            is_write_q <= 1'b0;
            wait_q     <= 4'd0;
        end else if ((state_q == StIdle) && cmd_valid) begin
            addr_q     <= mem_addr;
            data_q     <= write_data;
            is_write_q <= (mem_cmd == CmdWrite);
            wait_q     <= 4'(WAIT_STATES);
        end else if ((state_q == StAccess) && (wait_q != 4'd0)) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    // LED register loads at the end of the last ACCESS cycle of an LED write
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else if (last_access && is_write_q && hit_led) begin
            led_q <= data_q[IO_W-1:0];
        end
    end

    // Sticky bus error: illegal command in IDLE or a bad access; reset clears
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if (((state_q == StIdle) && (mem_cmd == CmdIllegal)) ||
                     (last_access && access_err)) begin
            bus_err_q <= 1'b1;
        end
    end

    // Outputs; reset gates the strobes so nothing fires on a reset edge
    always_comb begin
        ram_addr  = addr_q;
        ram_din   = data_q;
        ram_write = !reset && last_access && is_write_q && hit_ram;
        mem_ready = !reset && (state_q == StResp);
        led_out   = led_q;
        bus_err   = bus_err_q;
        read_data = '0;
        if (mem_ready && !is_write_q) begin
            if (hit_ram) begin
                read_data = ram_dout;
            end else if (hit_sw) begin
                read_data = DATA_W'(sw_sync_q);
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (0 and 3 wait states), each with a
// behavioural synchronous RAM, checked against a transaction-level model.
module tb_mem_bus_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 9;
    localparam int IOW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset      [2];
    logic [1:0]     mem_cmd    [2];
    logic [AW-1:0]  mem_addr   [2];
    logic [DW-1:0]  write_data [2];
    logic [DW-1:0]  read_data  [2];
    logic           mem_ready  [2];
    logic [AW-1:0]  ram_addr   [2];
    logic           ram_write  [2];
    logic [DW-1:0]  ram_din    [2];
    logic [DW-1:0]  ram_dout   [2];
    logic [IOW-1:0] sw_in      [2];
    logic [IOW-1:0] led_out    [2];
    logic           bus_err    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [256] = '{default: '0};

        always @(posedge clk) begin
            if (ram_write[g]) mem[ram_addr[g][7:0]] <= ram_din[g];
            ram_dout[g] <= mem[ram_addr[g][7:0]];
        end

        mem_bus_ctrl #(.WAIT_STATES((g == 0) ? 0 : 3)) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .mem_cmd   (mem_cmd[g]),
            .mem_addr  (mem_addr[g]),
            .write_data(write_data[g]),
            .read_data (read_data[g]),
            .mem_ready (mem_ready[g]),
            .ram_addr  (ram_addr[g]),
            .ram_write (ram_write[g]),
            .ram_din   (ram_din[g]),
            .ram_dout  (ram_dout[g]),
            .sw_in     (sw_in[g]),
            .led_out   (led_out[g]),
            .bus_err   (bus_err[g])
        );
    end

    // Reference model state
    logic [DW-1:0]  ref_mem [2][256];
    logic [IOW-1:0] ref_led [2];
    logic [IOW-1:0] ref_sw  [2];
    logic           ref_err [2];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        mem_cmd[k] = 2'b00;
        repeat (n) begin
            tick();
            check("idle_ready", 32'(mem_ready[k]), 0);
            check("idle_rdata", 32'(read_data[k]), 0);
        end
    endtask

    task automatic do_reset(input int k);
        reset[k]   = 1'b1;
        mem_cmd[k] = 2'b00;
        tick();
        tick();
        reset[k]   = 1'b0;
        ref_err[k] = 1'b0;
        ref_led[k] = '0;
        tick();
        check("rst_ready", 32'(mem_ready[k]), 0);
        check("rst_rdata", 32'(read_data[k]), 0);
        check("rst_ramwr", 32'(ram_write[k]), 0);
        check("rst_led",   32'(led_out[k]), 0);
        check("rst_err",   32'(bus_err[k]), 0);
    endtask

    // One transaction; extra=1 when issued in the RESP cycle of the previous one
    task automatic txn(input int k, input logic [1:0] cmd, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int extra);
        logic [DW-1:0] exp_rd = '0;
        int  exp_wr = 0;
        int  cyc = 0, wr_cnt = 0, wr_at = -1;
        bit  addr_ok = 1'b1, rd_zero = 1'b1, done = 1'b0;
        bit  in_ram = (addr < 9'd256);
        bit  is_led = (addr == 9'h100);
        bit  is_sw  = (addr == 9'h140);
        if (cmd == 2'b10) begin
            if (in_ram) begin
                ref_mem[k][addr[7:0]] = wd;
                exp_wr = 1;
            end else if (is_led) begin
                ref_led[k] = wd[IOW-1:0];
            end else begin
                ref_err[k] = 1'b1;
            end
        end else begin
            if (in_ram) exp_rd = ref_mem[k][addr[7:0]];
            else if (is_sw) exp_rd = DW'(ref_sw[k]);
            else ref_err[k] = 1'b1;
        end
        mem_cmd[k]    = cmd;
        mem_addr[k]   = addr;
        write_data[k] = wd;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
            if (ram_write[k] === 1'b1) begin
                wr_cnt++;
                wr_at = cyc;
            end
            if (cyc > extra && ram_addr[k] !== addr) addr_ok = 1'b0;
            if (mem_ready[k] === 1'b1) begin
                done = 1'b1;
            end else if (read_data[k] !== '0) begin
                rd_zero = 1'b0;
            end
        end
        check("latency", cyc, 2 + ws(k) + extra);
        check("rdata",   32'(read_data[k]), 32'(cmd == 2'b01 ? exp_rd : '0));
        check("wr_cnt",  wr_cnt, exp_wr);
        if (exp_wr == 1) check("wr_cycle", wr_at, 1 + ws(k) + extra);
        check("ram_addr_held", 32'(addr_ok), 1);
        check("rdata_idle0",   32'(rd_zero), 1);
        check("led",     32'(led_out[k]), 32'(ref_led[k]));
        check("bus_err", 32'(bus_err[k]), 32'(ref_err[k]));
    endtask

    task automatic illegal(input int k);
        mem_cmd[k]  = 2'b11;
        mem_addr[k] = 9'($urandom_range(0, 511));
        ref_err[k]  = 1'b1;
        tick();
        check("illegal_err", 32'(bus_err[k]), 1);
        check("illegal_ready", 32'(mem_ready[k]), 0);
        idle(k, 3);
    endtask

    // Reset lands in the last ACCESS cycle of a RAM write
    task automatic reset_mid(input int k, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        mem_cmd[k]    = 2'b10;
        mem_addr[k]   = addr;
        write_data[k] = wd;
        repeat (1 + ws(k)) tick();
        check("pre_rst_wr", 32'(ram_write[k]), 1);
        reset[k]   = 1'b1;
        mem_cmd[k] = 2'b00;
        #1;
        check("rst_wr_gated", 32'(ram_write[k]), 0);
        check("rst_ready_gated", 32'(mem_ready[k]), 0);
        tick();
        check("post_rst_ready", 32'(mem_ready[k]), 0);
        check("post_rst_wr", 32'(ram_write[k]), 0);
        reset[k]   = 1'b0;
        ref_err[k] = 1'b0;
        ref_led[k] = '0;
        tick();
        check("post_rst_err", 32'(bus_err[k]), 0);
        check("post_rst_ready2", 32'(mem_ready[k]), 0);
    endtask

    task automatic random_txns(input int k, input int n);
        logic [AW-1:0] a;
        logic [1:0]    c;
        int            r;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sw_in[k]  = IOW'($urandom);
                ref_sw[k] = sw_in[k];
                idle(k, 2);
            end
            if ($urandom_range(0, 9) == 0) begin
                illegal(k);
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6) a = 9'($urandom_range(0, 15));
                else if (r == 6) a = 9'h100;
                else if (r == 7) a = 9'h140;
                else begin
                    a = 9'($urandom_range(256, 511));
                    if (a == 9'h100 || a == 9'h140) a = 9'h1F0;
                end
                c = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                txn(k, c, a, DW'($urandom), 0);
                idle(k, $urandom_range(1, 3));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k]      = 1'b1;
            mem_cmd[k]    = 2'b00;
            mem_addr[k]   = '0;
            write_data[k] = '0;
            sw_in[k]      = '0;
            ref_sw[k]     = '0;
            ref_led[k]    = '0;
            ref_err[k]    = 1'b0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            txn(k, 2'b10, 9'h012, 16'hBEEF, 0);
            idle(k, 1);
            txn(k, 2'b01, 9'h012, 16'h0000, 0);
            idle(k, 1);
            txn(k, 2'b01, 9'h005, 16'h0000, 0);
            idle(k, 1);
            txn(k, 2'b10, 9'h100, 16'hFFFF, 0);
            idle(k, 1);
            sw_in[k]  = 10'h2A5;
            ref_sw[k] = 10'h2A5;
            idle(k, 2);
            txn(k, 2'b01, 9'h140, 16'h0000, 0);
            idle(k, 1);
            txn(k, 2'b01, 9'h1F0, 16'h0000, 0);
            idle(k, 2);
            check("err_sticky", 32'(bus_err[k]), 1);
            illegal(k);
            do_reset(k);
            txn(k, 2'b10, 9'h003, 16'h1111, 0);
            idle(k, 1);
            reset_mid(k, 9'h003, 16'h2222);
            txn(k, 2'b01, 9'h003, 16'h0000, 0);
            idle(k, 1);
            txn(k, 2'b10, 9'h020, 16'h00A1, 0);
            txn(k, 2'b10, 9'h021, 16'h00B2, 1);
            idle(k, 1);
            txn(k, 2'b01, 9'h020, 16'h0000, 0);
            idle(k, 1);
            txn(k, 2'b01, 9'h021, 16'h0000, 0);
            idle(k, 1);
            random_txns(k, 40);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
